// File: rtl/frame_pixel_packer.sv
// frame_pixel_packer: packs an RGB565 pixel stream framed by vsync/de into
// 32-bit words for the DDR write FIFO, pulses wr_load at each frame start,
// counts frames/lines and flags bad frame geometry (sticky geom_err).
// Optional feature macro: PIXPACK_LINE_PAD_EN -- when defined, an odd pixel
// left over at the end of a line is flushed as {16'h0000, pixel}; otherwise
// it is dropped and geom_err is raised at once.
module frame_pixel_packer #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cam_vsync,
  input  logic        cam_de,
  input  logic [15:0] cam_data,
  output logic        wr_load,
  output logic        wrfifo_wren,
  output logic [31:0] wrfifo_din,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic [10:0] line_cnt,
  output logic        geom_err
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state, state_nx;
  logic        vs_r, vs_q, de_r, de_q;
  logic [15:0] data_r;
  logic [15:0] hold;
  logic        held;
  logic [31:0] pair_word;
  logic        pair_vld;
  logic [11:0] pix_cnt;
  logic        line_act;
  logic        vs_rise, de_rise, start, fend, pix_ok, line_end;
  logic [11:0] lines_tot;
  logic [10:0] line_inc;

  // Input register stage; edges are taken from these copies only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_r <= 1'b0; vs_q <= 1'b0; de_r <= 1'b0; de_q <= 1'b0; data_r <= '0;
    end else begin
      vs_r <= cam_vsync; vs_q <= vs_r;
      de_r <= cam_de;    de_q <= de_r;
      data_r <= cam_data;
    end
  end

  // Capture state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and per-cycle frame/line events.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    fend     = 1'b0;
    vs_rise  = vs_r & ~vs_q;
    de_rise  = de_r & ~de_q;
    if (vs_rise) begin
      fend = (state == ACTIVE);
      if (enable) begin
        start    = 1'b1;
        state_nx = ACTIVE;
      end else begin
        state_nx = IDLE;
      end
    end
    // A pixel only counts if its line started while capturing, so a line
    // cut by vsync does not leak its tail into the next frame.
    pix_ok    = (state == ACTIVE) & ~vs_rise & de_r & (line_act | de_rise);
    line_end  = line_act & ~de_r & ~vs_rise;
    lines_tot = {1'b0, line_cnt} + {11'd0, line_act};
    line_inc  = (line_cnt == 11'h7FF) ? line_cnt : line_cnt + 11'd1;
  end

  // Pairing, counters and geometry checks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0; held <= 1'b0; pair_word <= '0; pair_vld <= 1'b0;
      pix_cnt <= '0; line_act <= 1'b0; line_cnt <= '0; frame_cnt <= '0;
      geom_err <= 1'b0; wr_load <= 1'b0; frame_done <= 1'b0;
    end else begin
      wr_load    <= start;
      frame_done <= fend;
      pair_vld   <= 1'b0;
      if (start || fend) begin
        // Frame boundary: an unfinished line is truncated and still counted.
        held     <= 1'b0;
        pix_cnt  <= '0;
        line_act <= 1'b0;
        if (line_act && pix_cnt != 12'(H_PIXELS)) geom_err <= 1'b1;
        if (fend && lines_tot != 12'(V_LINES))    geom_err <= 1'b1;
        if (fend) frame_cnt <= frame_cnt + 8'd1;
        if (start)         line_cnt <= '0;
        else if (line_act) line_cnt <= line_inc;
      end else if (pix_ok) begin
        line_act <= 1'b1;
        if (pix_cnt != 12'hFFF) pix_cnt <= pix_cnt + 12'd1;
        if (!held) begin
          hold <= data_r;
          held <= 1'b1;
        end else begin
          pair_word <= {data_r, hold};
          pair_vld  <= 1'b1;
          held      <= 1'b0;
        end
      end else if (line_end) begin
        line_act <= 1'b0;
        line_cnt <= line_inc;
        pix_cnt  <= '0;
        if (pix_cnt != 12'(H_PIXELS)) geom_err <= 1'b1;
        if (held) begin
          held <= 1'b0;
`ifdef PIXPACK_LINE_PAD_EN
          pair_word <= {16'h0000, hold};
          pair_vld  <= 1'b1;
`else
          geom_err <= 1'b1;
`endif
        end
      end
    end
  end

  // Output stage: strobe the FIFO, hold the data word between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrfifo_wren <= 1'b0;
      wrfifo_din  <= '0;
    end else begin
      wrfifo_wren <= pair_vld;
      if (pair_vld) wrfifo_din <= pair_word;
    end
  end

endmodule

// File: tb/tb_frame_pixel_packer.sv
// Self-checking bench for frame_pixel_packer with a reduced frame geometry.
// The reference model builds expected FIFO words, frame counts and the
// geometry flag from the pixel lists and line counts the bench sends.
module tb_frame_pixel_packer;
  localparam int H = 8;
  localparam int V = 4;
`ifdef PIXPACK_LINE_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, cam_vsync, cam_de;
  logic [15:0] cam_data;
  logic        wr_load, wrfifo_wren, frame_done, geom_err;
  logic [31:0] wrfifo_din;
  logic [7:0]  frame_cnt;
  logic [10:0] line_cnt;

  frame_pixel_packer #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cam_vsync(cam_vsync),
    .cam_de(cam_de), .cam_data(cam_data), .wr_load(wr_load),
    .wrfifo_wren(wrfifo_wren), .wrfifo_din(wrfifo_din),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
    .geom_err(geom_err));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed traffic with the cycle each strobe was seen.
  logic [31:0] got_q[$];
  int wren_cyc[$], load_cyc[$], done_cyc[$];
  always @(negedge clk) begin
    if (wrfifo_wren) begin got_q.push_back(wrfifo_din); wren_cyc.push_back(cyc); end
    if (wr_load)    load_cyc.push_back(cyc);
    if (frame_done) done_cyc.push_back(cyc);
  end

  // Reference model state.
  logic [31:0] exp_q[$];
  int  sec_cyc[$];
  bit  exp_geom, m_active;
  int  exp_frames, m_lines, vs_cyc;
  int  n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    got_q.delete(); wren_cyc.delete(); load_cyc.delete(); done_cyc.delete();
    exp_q.delete(); sec_cyc.delete();
  endtask

  task automatic idle(input int n);
    cam_de = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; cam_vsync = 1'b0; cam_de = 1'b0; cam_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_geom = 1'b0; m_active = 1'b0; exp_frames = 0; m_lines = 0;
    clr();
    idle(2);
  endtask

  // One-cycle vsync pulse; model closes the current frame if capturing.
  task automatic vsync(input bit en);
    enable = en; cam_vsync = 1'b1; vs_cyc = cyc;
    @(negedge clk);
    cam_vsync = 1'b0;
    if (m_active) begin
      exp_frames++;
      if (m_lines != V) exp_geom = 1'b1;
    end
    m_active = en; m_lines = 0;
    idle(3);
  endtask

  // One line of n pixels: base!=0 gives base, base+1, ...; else random.
  task automatic line(input int n, input logic [15:0] base);
    logic [15:0] px[$];
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      p = (base != 16'd0) ? base + 16'(i) : 16'($urandom);
      px.push_back(p);
      cam_de = 1'b1; cam_data = p;
      if (i % 2 == 1) sec_cyc.push_back(cyc);
      @(negedge clk);
    end
    idle(4);
    if (m_active) begin
      for (int i = 0; i + 1 < n; i += 2) exp_q.push_back({px[i+1], px[i]});
      if (n % 2 == 1 && PAD) exp_q.push_back({16'h0000, px[n-1]});
      if (n != H) exp_geom = 1'b1;
      m_lines++;
    end
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_word"}, got_q[i], exp_q[i]);
    got_q.delete(); exp_q.delete(); wren_cyc.delete(); sec_cyc.delete();
  endtask

  initial begin
    int c0, nf, nl, len;
    // Reset values while reset is held.
    rst = 1'b1; enable = 1'b0; cam_vsync = 1'b0; cam_de = 1'b0; cam_data = '0;
    @(negedge clk);
    chk("rst_wr_load", wr_load, 0);
    chk("rst_wren", wrfifo_wren, 0);
    chk("rst_din", wrfifo_din, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_geom", geom_err, 0);
    do_reset();

    // Frame start from IDLE: single wr_load two clocks after the pin edge.
    vsync(1'b1);
    chk("load_count", load_cyc.size(), 1);
    if (load_cyc.size() > 0) chk("load_latency", load_cyc[0], vs_cyc + 2);
    chk("start_done_count", done_cyc.size(), 0);
    chk("start_wren_count", got_q.size(), 0);

    // Four sequential pixels: two words, three clocks after each pair's end.
    line(4, 16'h0001);
    chk("w4_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("w4_first", got_q[0], 32'h00020001);
      chk("w4_second", got_q[1], 32'h00040003);
      chk("w4_lat0", wren_cyc[0], sec_cyc[0] + 3);
      chk("w4_lat1", wren_cyc[1], sec_cyc[1] + 3);
    end
    chk("w4_din_hold", wrfifo_din, 32'h00040003);
    chk("w4_geom", geom_err, exp_geom);
    chk("w4_line_cnt", line_cnt, m_lines);
    chk_words("w4");

    // Full correctly sized frame, then restart.
    do_reset();
    vsync(1'b1);
    for (int l = 0; l < V; l++) line(H, 16'd0);
    chk("full_line_cnt", line_cnt, m_lines);
    chk("full_geom_mid", geom_err, 0);
    c0 = load_cyc.size();
    vsync(1'b1);
    chk_words("full");
    chk("full_done_count", done_cyc.size(), 1);
    chk("full_load_count", load_cyc.size(), c0 + 1);
    if (done_cyc.size() == 1 && load_cyc.size() == c0 + 1) begin
      chk("full_done_lat", done_cyc[0], vs_cyc + 2);
      chk("full_done_with_load", done_cyc[0], load_cyc[c0]);
    end
    chk("full_frame_cnt", frame_cnt, exp_frames[7:0]);
    chk("full_geom", geom_err, exp_geom);
    chk("full_line_restart", line_cnt, 0);

    // Odd-length line 0xA..0xE.
    line(5, 16'h000A);
    chk_words("odd");
    chk("odd_geom", geom_err, 1);

    // Stop capture: frame ends without wr_load, later lines are ignored.
    do_reset();
    vsync(1'b1);
    line(H, 16'd0);
    vsync(1'b0);
    chk("stop_done_count", done_cyc.size(), 1);
    chk("stop_load_count", load_cyc.size(), 1);
    chk("stop_frame_cnt", frame_cnt, exp_frames[7:0]);
    chk("stop_geom", geom_err, exp_geom);
    line(H, 16'd0);
    chk_words("stop");

    // Reset in the middle of a line.
    vsync(1'b1);
    for (int i = 0; i < 3; i++) begin
      cam_de = 1'b1; cam_data = 16'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wren", wrfifo_wren, 0);
    chk("mid_rst_load", wr_load, 0);
    chk("mid_rst_frame_cnt", frame_cnt, 0);
    chk("mid_rst_line_cnt", line_cnt, 0);
    chk("mid_rst_geom", geom_err, 0);
    clr();
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    chk("mid_rst_no_word", got_q.size(), 0);

    // Randomized frames: random enables, line counts and line lengths.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      vsync($urandom_range(0, 3) != 0);
      nl = $urandom_range(V - 1, V + 1);
      for (int l = 0; l < nl; l++) begin
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 11) : H;
        line(len, 16'd0);
      end
      nf = exp_frames;
    end
    vsync(1'b1);
    chk_words("rand");
    chk("rand_frame_cnt", frame_cnt, exp_frames[7:0]);
    chk("rand_done_count", done_cyc.size(), exp_frames);
    chk("rand_geom", geom_err, exp_geom);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
